// File: rtl/ysyx_22041071_mem_stage_pkg.sv
// Shared widths, access-size codes and MEM stage state encoding.
package ysyx_22041071_mem_stage_pkg;

   localparam int ADDR_BUS = 64;
   localparam int DATA_BUS = 64;

   // funct3[1:0] access size
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

endpackage

// File: rtl/ysyx_22041071_lsu_align.sv
// Byte-lane alignment for a 64-bit data bus: store mask/data placement,
// load lane extraction with sign/zero extension, natural-alignment check.
module ysyx_22041071_lsu_align
   import ysyx_22041071_mem_stage_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic [2:0]          off,
   input  logic [DATA_BUS-1:0] rt_data,
   input  logic [DATA_BUS-1:0] rdata,
   output logic [7:0]          wmask,
   output logic [DATA_BUS-1:0] wdata,
   output logic [DATA_BUS-1:0] load_data,
   output logic                misalign
);

   logic [5:0]          sh;
   logic [DATA_BUS-1:0] raw;

   assign sh    = {off, 3'b000};
   assign wdata = rt_data << sh;
   assign raw   = rdata >> sh;

   // Lane mask and alignment check by access size
   always_comb begin
      wmask    = 8'h00;
      misalign = 1'b0;
      case (funct3[1:0])
         SZ_B: begin wmask = 8'h01 << off; misalign = 1'b0;      end
         SZ_H: begin wmask = 8'h03 << off; misalign = off[0];    end
         SZ_W: begin wmask = 8'h0F << off; misalign = |off[1:0]; end
         SZ_D: begin wmask = 8'hFF;        misalign = |off;      end
      endcase
   end

   // Truncate shifted read data to the access size; funct3[2] selects zero-extension
   always_comb begin
      load_data = raw;
      case (funct3[1:0])
         SZ_B: load_data = funct3[2] ? {{(DATA_BUS-8){1'b0}}, raw[7:0]}
                                     : {{(DATA_BUS-8){raw[7]}}, raw[7:0]};
         SZ_H: load_data = funct3[2] ? {{(DATA_BUS-16){1'b0}}, raw[15:0]}
                                     : {{(DATA_BUS-16){raw[15]}}, raw[15:0]};
         SZ_W: load_data = funct3[2] ? {{(DATA_BUS-32){1'b0}}, raw[31:0]}
                                     : {{(DATA_BUS-32){raw[31]}}, raw[31:0]};
         SZ_D: load_data = raw;
      endcase
   end

endmodule

// File: rtl/ysyx_22041071_mem_stage.sv
// MEM pipeline stage: one EX bundle per handshake, single data-memory access,
// registered WB bundle and a combinational forwarding tap.
//
//   state   | meaning
//   IDLE    | can accept a bundle; ALU and misaligned bundles complete here
//   REQ     | dm_req_valid high, fields held until dm_req_ready
//   WAIT    | request accepted, waiting for dm_resp_valid
//   DONE    | read data captured, waiting for room in the output register
module ysyx_22041071_mem_stage
   import ysyx_22041071_mem_stage_pkg::*;
#(
   parameter int AW = ADDR_BUS,
   parameter int DW = DATA_BUS
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_pc,
   input  logic [31:0]   in_ins,
   input  logic          in_mem_w_en,
   input  logic          in_wb_sel,
   input  logic          in_reg_w_en,
   input  logic [4:0]    in_rdest,
   input  logic [DW-1:0] in_rt_data,
   input  logic [DW-1:0] in_alu_result,
   output logic          dm_req_valid,
   input  logic          dm_req_ready,
   output logic [AW-1:0] dm_req_addr,
   output logic          dm_req_we,
   output logic [7:0]    dm_req_wmask,
   output logic [DW-1:0] dm_req_wdata,
   input  logic          dm_resp_valid,
   input  logic [DW-1:0] dm_resp_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_pc,
   output logic [31:0]   out_ins,
   output logic          out_reg_w_en,
   output logic [4:0]    out_rdest,
   output logic [DW-1:0] out_wb_data,
   output logic          fwd_reg_w_en,
   output logic [4:0]    fwd_rdest,
   output logic [DW-1:0] fwd_data,
   output logic          misalign
);

   mem_state_t    state;
   logic [AW-1:0] pc_q, addr_q;
   logic [31:0]   ins_q;
   logic          mem_w_en_q, reg_w_en_q;
   logic [4:0]    rdest_q;
   logic [DW-1:0] rt_q, rdata_q;

   logic          idle, out_free, accept, is_mem, load_direct, load_mem;
   logic [2:0]    al_funct3, al_off;
   logic [DW-1:0] al_rt, al_wdata, al_load;
   logic [7:0]    al_wmask;
   logic          al_misalign;

   assign idle     = (state == ST_IDLE);
   assign out_free = !out_valid || out_ready;
   assign in_ready = idle && out_free;
   assign accept   = in_valid && in_ready;
   assign is_mem   = in_mem_w_en || in_wb_sel;

   // In IDLE the aligner checks the incoming bundle; afterwards it serves the captured one
   assign al_funct3 = idle ? in_ins[14:12]      : ins_q[14:12];
   assign al_off    = idle ? in_alu_result[2:0] : addr_q[2:0];
   assign al_rt     = idle ? in_rt_data         : rt_q;

   ysyx_22041071_lsu_align u_align (
      .funct3    (al_funct3),
      .off       (al_off),
      .rt_data   (al_rt),
      .rdata     (rdata_q),
      .wmask     (al_wmask),
      .wdata     (al_wdata),
      .load_data (al_load),
      .misalign  (al_misalign)
   );

   assign dm_req_valid = (state == ST_REQ);
   assign dm_req_addr  = {addr_q[AW-1:3], 3'b000};
   assign dm_req_we    = mem_w_en_q;
   assign dm_req_wmask = al_wmask;
   assign dm_req_wdata = al_wdata;

   // Sequencing of the single memory access, plus the misalign pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         misalign <= 1'b0;
      end else begin
         misalign <= 1'b0;
         case (state)
            ST_IDLE: if (accept && is_mem) begin
               if (al_misalign) misalign <= 1'b1;
               else             state    <= ST_REQ;
            end
            ST_REQ:  if (dm_req_ready)  state <= ST_WAIT;
            ST_WAIT: if (dm_resp_valid) state <= ST_DONE;
            ST_DONE: if (out_free)      state <= ST_IDLE;
         endcase
      end
   end

   // Bundle capture on accept and read-data capture on response; datapath only
   always_ff @(posedge clk) begin
      if (accept) begin
         pc_q       <= in_pc;
         ins_q      <= in_ins;
         mem_w_en_q <= in_mem_w_en;
         reg_w_en_q <= in_reg_w_en;
         rdest_q    <= in_rdest;
         rt_q       <= in_rt_data;
         addr_q     <= in_alu_result[AW-1:0];
      end
      if (state == ST_WAIT && dm_resp_valid) rdata_q <= dm_resp_rdata;
   end

   // Misaligned accesses travel to WB as no-ops so the bundle is not lost
   assign load_direct = accept && (!is_mem || al_misalign);
   assign load_mem    = (state == ST_DONE) && out_free;

   // WB output register: load from EX directly or from a completed access, else drain/hold
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_ins      <= '0;
         out_reg_w_en <= 1'b0;
         out_rdest    <= '0;
         out_wb_data  <= '0;
      end else if (load_direct) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_ins      <= in_ins;
         out_reg_w_en <= in_reg_w_en && !is_mem;
         out_rdest    <= in_rdest;
         out_wb_data  <= in_alu_result;
      end else if (load_mem) begin
         out_valid    <= 1'b1;
         out_pc       <= pc_q;
         out_ins      <= ins_q;
         out_reg_w_en <= reg_w_en_q;
         out_rdest    <= rdest_q;
         out_wb_data  <= mem_w_en_q ? '0 : al_load;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   assign fwd_reg_w_en = out_valid && out_reg_w_en;
   assign fwd_rdest    = out_valid ? out_rdest   : '0;
   assign fwd_data     = out_valid ? out_wb_data : '0;

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
// Scoreboard bench for the MEM stage: expected WB bundles and memory requests are
// queued when a bundle is driven, and popped when the DUT presents them.
module tb_ysyx_22041071_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_ins;
   logic        in_mem_w_en, in_wb_sel, in_reg_w_en;
   logic [4:0]  in_rdest;
   logic [63:0] in_rt_data, in_alu_result;
   logic        dm_req_valid, dm_req_ready;
   logic [63:0] dm_req_addr;
   logic        dm_req_we;
   logic [7:0]  dm_req_wmask;
   logic [63:0] dm_req_wdata;
   logic        dm_resp_valid;
   logic [63:0] dm_resp_rdata;
   logic        out_valid, out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_ins;
   logic        out_reg_w_en;
   logic [4:0]  out_rdest;
   logic [63:0] out_wb_data;
   logic        fwd_reg_w_en;
   logic [4:0]  fwd_rdest;
   logic [63:0] fwd_data;
   logic        misalign;

   ysyx_22041071_mem_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
      .in_mem_w_en(in_mem_w_en), .in_wb_sel(in_wb_sel), .in_reg_w_en(in_reg_w_en),
      .in_rdest(in_rdest), .in_rt_data(in_rt_data), .in_alu_result(in_alu_result),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
      .dm_req_we(dm_req_we), .dm_req_wmask(dm_req_wmask), .dm_req_wdata(dm_req_wdata),
      .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
      .out_reg_w_en(out_reg_w_en), .out_rdest(out_rdest), .out_wb_data(out_wb_data),
      .fwd_reg_w_en(fwd_reg_w_en), .fwd_rdest(fwd_rdest), .fwd_data(fwd_data),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] data;
      logic        w_en;
      logic [4:0]  rdest;
      bit          chk_data;
   } out_t;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [7:0]  mask;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } req_t;

   out_t out_q[$];
   req_t req_q[$];

   int total = 0;
   int bad   = 0;
   int stall_cnt = 0;
   bit hold_resp = 0, stray_req = 0, hs_pending = 0, mon_en = 0;
   int mis_seen = 0, mis_exp = 0;
   logic [63:0] resp_data = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [7:0] exp_mask(input logic [2:0] f3, input logic [2:0] off);
      logic [7:0] m = '0;
      for (int i = 0; i < nbytes(f3); i++)
         if (int'(off) + i < 8) m[int'(off) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] rt, input logic [2:0] off);
      logic [63:0] w = '0;
      for (int j = int'(off); j < 8; j++) w[8*j +: 8] = rt[8*(j - int'(off)) +: 8];
      return w;
   endfunction

   function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] rd);
      logic [63:0] v = '0;
      int n = nbytes(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
      if (!f3[2] && v[8*n - 1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic send(input logic [63:0] pc, input logic [2:0] f3, input bit st, input bit ld,
                       input bit wen, input logic [4:0] rd, input logic [63:0] rt,
                       input logic [63:0] alu, input logic [63:0] rdata, input bit expect_out);
      out_t o;
      req_t r;
      logic [2:0] off;
      bit mem, mis;
      int guard = 0;
      off = alu[2:0];
      mem = st || ld;
      mis = mem && ((int'(off) % nbytes(f3)) != 0);
      o.pc = pc; o.rdest = rd; o.chk_data = 1; o.w_en = wen;
      if (!mem)      o.data = alu;
      else if (mis) begin o.data = '0; o.w_en = 1'b0; o.chk_data = 0; mis_exp++; end
      else if (st)   o.data = '0;
      else           o.data = exp_load(f3, off, rdata);
      if (mem && !mis) begin
         r.addr = {alu[63:3], 3'b000}; r.we = st; r.mask = exp_mask(f3, off);
         r.wdata = exp_wdata(rt, off); r.rdata = rdata;
         req_q.push_back(r);
      end
      if (expect_out) out_q.push_back(o);
      in_valid = 1'b1; in_pc = pc; in_ins = {17'b0, f3, 5'b0, 7'h03};
      in_mem_w_en = st; in_wb_sel = ld; in_reg_w_en = wen; in_rdest = rd;
      in_rt_data = rt; in_alu_result = alu;
      @(negedge clk);
      while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
      chk("accept_to", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((req_q.size() != 0 || out_q.size() != 0) && g < 500) begin @(posedge clk); g++; end
      chk("drain_to", req_q.size() + out_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // Memory model: stalls dm_req_ready on request, answers one cycle after acceptance
   initial begin
      req_t r;
      dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;
      forever begin
         @(negedge clk);
         dm_resp_valid = 1'b0;
         if (stray_req) begin
            dm_resp_valid = 1'b1; dm_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF; stray_req = 0;
         end else if (hs_pending && !hold_resp) begin
            dm_resp_valid = 1'b1; dm_resp_rdata = resp_data;
         end
         hs_pending = 0;
         if (dm_req_valid && stall_cnt > 0) begin dm_req_ready = 1'b0; stall_cnt--; end
         else dm_req_ready = 1'b1;
         if (mon_en && dm_req_valid) begin
            if (req_q.size() == 0) chk("req_unexp", dm_req_valid, 1'b0);
            else if (!dm_req_ready) begin
               chk("stall_addr", dm_req_addr, req_q[0].addr);
               chk("stall_mask", dm_req_wmask, req_q[0].mask);
               chk("stall_we", dm_req_we, req_q[0].we);
               if (req_q[0].we) chk("stall_wdata", dm_req_wdata, req_q[0].wdata);
               chk("stall_in_ready", in_ready, 1'b0);
            end else begin
               r = req_q.pop_front();
               chk("req_addr", dm_req_addr, r.addr);
               chk("req_we", dm_req_we, r.we);
               chk("req_mask", dm_req_wmask, r.mask);
               if (r.we) chk("req_wdata", dm_req_wdata, r.wdata);
               resp_data = r.rdata;
               hs_pending = 1;
            end
         end
      end
   end

   // WB side: forward tap against the pending bundle, pop on transfer
   initial begin
      out_t o;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (misalign) mis_seen++;
            if (out_valid) begin
               if (out_q.size() == 0) chk("out_unexp", out_valid, 1'b0);
               else begin
                  chk("fwd_wen", fwd_reg_w_en, out_q[0].w_en);
                  chk("fwd_rd", fwd_rdest, out_q[0].rdest);
                  if (out_q[0].chk_data) chk("fwd_data", fwd_data, out_q[0].data);
                  if (out_ready) begin
                     o = out_q.pop_front();
                     chk("out_pc", out_pc, o.pc);
                     chk("out_wen", out_reg_w_en, o.w_en);
                     chk("out_rd", out_rdest, o.rdest);
                     if (o.chk_data) chk("out_data", out_wb_data, o.data);
                  end
               end
            end else begin
               chk("fwd_idle_wen", fwd_reg_w_en, 1'b0);
               chk("fwd_idle_data", fwd_data, 64'h0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0]  sz;
      logic [2:0]  f3, off;
      bit          st, u;
      logic [63:0] alu;
      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_ins = '0; in_mem_w_en = 1'b0;
      in_wb_sel = 1'b0; in_reg_w_en = 1'b0; in_rdest = '0; in_rt_data = '0;
      in_alu_result = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_req_valid", dm_req_valid, 1'b0);
      chk("rst_misalign", misalign, 1'b0);
      chk("rst_wen", out_reg_w_en, 1'b0);
      chk("rst_pc", out_pc, 64'h0);
      chk("rst_ins", out_ins, 64'h0);
      chk("rst_rd", out_rdest, 64'h0);
      chk("rst_wb", out_wb_data, 64'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      mon_en = 1;
      @(posedge clk); #1;

      // ALU pass-through, one-cycle latency
      send(64'h8000_0000, 3'd0, 0, 0, 1, 5'd5, 64'h0, 64'h1234, 64'h0, 1);
      @(negedge clk);
      chk("alu_latency", out_valid, 1'b1);
      chk("alu_wb", out_wb_data, 64'h1234);
      chk("alu_noreq", dm_req_valid, 1'b0);
      @(posedge clk); #1;

      // Directed loads/stores
      send(64'h8000_0004, 3'd0, 0, 1, 1, 5'd6, 64'h0, 64'h0000_0000_8000_1003,
           64'h0000_0000_8000_0000, 1);
      send(64'h8000_0008, 3'd5, 0, 1, 1, 5'd7, 64'h0, 64'h0000_0000_8000_2006,
           64'h8001_0000_0000_0000, 1);
      send(64'h8000_000C, 3'd1, 1, 0, 0, 5'd0, 64'hBEEF, 64'h0000_0000_8000_3002,
           64'h0, 1);
      drain();
      stall_cnt = 3;
      send(64'h8000_0010, 3'd2, 0, 1, 1, 5'd8, 64'h0, 64'h0000_0000_8000_4004,
           64'hF234_5678_0000_0000, 1);
      drain();
      send(64'h8000_0014, 3'd3, 0, 1, 1, 5'd9, 64'h0, 64'h0000_0000_8000_5000,
           64'h0123_4567_89AB_CDEF, 1);
      send(64'h8000_0018, 3'd3, 1, 0, 0, 5'd0, 64'h0123_4567_89AB_CDEF,
           64'h0000_0000_8000_6008, 64'h0, 1);
      send(64'h8000_001C, 3'd6, 0, 1, 1, 5'd10, 64'h0, 64'h0000_0000_8000_7000,
           64'hFFFF_FFFF_8765_4321, 1);
      drain();

      // Output back-pressure: held result, no input accepted, single transfer on release
      out_ready = 1'b0;
      send(64'h8000_0020, 3'd0, 0, 0, 1, 5'd11, 64'h0, 64'hAAAA, 64'h0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_wb", out_wb_data, 64'hAAAA);
         chk("hold_pc", out_pc, 64'h8000_0020);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(64'h8000_0024, 3'd0, 0, 0, 1, 5'd12, 64'h0, 64'hBBBB, 64'h0, 1);
      drain();

      // Misaligned accesses: no request, misalign pulse, reg write suppressed
      send(64'h8000_0028, 3'd2, 0, 1, 1, 5'd13, 64'h0, 64'h0000_0000_8000_8002, 64'h0, 1);
      send(64'h8000_002C, 3'd3, 1, 0, 0, 5'd0, 64'h55, 64'h0000_0000_8000_9004, 64'h0, 1);
      drain();

      // Reset while waiting for a response, then a stray response in IDLE
      hold_resp = 1;
      send(64'h8000_0030, 3'd2, 0, 1, 1, 5'd14, 64'h0, 64'h0000_0000_8000_A000,
           64'h1111_2222_3333_4444, 0);
      for (int g = 0; g < 100 && req_q.size() != 0; g++) @(posedge clk);
      chk("rst_wait_req", req_q.size(), 0);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; hold_resp = 0; stray_req = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stray_out_valid", out_valid, 1'b0);
         chk("stray_req_valid", dm_req_valid, 1'b0);
         chk("stray_in_ready", in_ready, 1'b1);
      end
      @(posedge clk); #1;
      send(64'h8000_0034, 3'd0, 0, 0, 1, 5'd15, 64'h0, 64'h600D, 64'h0, 1);
      drain();

      // Randomised aligned loads/stores with random request stalls
      for (int it = 0; it < 16; it++) begin
         sz  = 2'($urandom_range(0, 3));
         st  = bit'($urandom_range(0, 1));
         u   = (sz != 2'd3 && !st) ? bit'($urandom_range(0, 1)) : 1'b0;
         f3  = {u, sz};
         off = 3'(($urandom_range(0, 7) / nbytes(f3)) * nbytes(f3));
         alu = {$urandom, $urandom};
         alu[2:0] = off;
         stall_cnt = int'($urandom_range(0, 2));
         send(64'h9000_0000 + 64'(4 * it), f3, st, !st, !st, 5'(it + 1),
              {$urandom, $urandom}, alu, {$urandom, $urandom}, 1);
         drain();
      end

      chk("misalign_count", mis_seen, mis_exp);
      chk("queues_empty", out_q.size() + req_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
